// File: rtl/sb_pkg.sv
// Shared sideband decoder types: opcodes, header bit positions, header struct and FSM states.
package sb_pkg;

    localparam logic [4:0] SB_OPC_MSG_NODATA = 5'b10010;
    localparam logic [4:0] SB_OPC_MSG_DATA   = 5'b11011;

    localparam int SB_HDR_DP_BIT = 63;
    localparam int SB_HDR_CP_BIT = 62;

    typedef struct packed {
        logic        dp;
        logic        cp;
        logic [2:0]  srcid;
        logic [2:0]  dstid;
        logic [7:0]  msgcode;
        logic [7:0]  msgsubcode;
        logic [15:0] msginfo;
        logic [18:0] rsvd;
        logic [4:0]  opcode;
    } sb_hdr_t;

    typedef enum logic [1:0] {
        SB_ST_IDLE = 2'd0,
        SB_ST_DATA = 2'd1,
        SB_ST_OUT  = 2'd2
    } sb_state_e;

endpackage

// File: rtl/sb_parity_chk.sv
// Combinational CP/DP pass flags for a header and its optional data word.
module sb_parity_chk
    import sb_pkg::*;
(
    input  sb_hdr_t     hdr_i,
    input  logic [63:0] data_i,
    input  logic        has_data_i,
    output logic        cp_ok_o,
    output logic        dp_ok_o
);

    // CP equals the XOR of bits [61:0], i.e. bits [62:0] have even parity.
    assign cp_ok_o = ~(^hdr_i[SB_HDR_CP_BIT:0]);
    assign dp_ok_o = has_data_i ? (hdr_i[SB_HDR_DP_BIT] == ^data_i)
                                : (hdr_i[SB_HDR_DP_BIT] == 1'b0);

endmodule

// File: rtl/sb_msg_decoder.sv
// Sideband message decoder: header (+ data word) -> decoded fields; parity checks under SB_PARITY_CHECK_EN.
// Latency: word_ack_o and msg_valid_o one cycle after the completing capture; error pulses one cycle after the event.
// Backpressure: while a message waits for msg_ready_i no word is acknowledged.
module sb_msg_decoder
    import sb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk_100MHz,
    input  logic                 reset_n,
    input  logic                 enable_i,
    input  logic [63:0]          word_i,
    input  logic                 word_valid_i,
    output logic                 word_ack_o,
    output logic                 msg_valid_o,
    input  logic                 msg_ready_i,
    output logic [4:0]           opcode_o,
    output logic [2:0]           srcid_o,
    output logic [2:0]           dstid_o,
    output logic [7:0]           msgcode_o,
    output logic [7:0]           msgsubcode_o,
    output logic [15:0]          msginfo_o,
    output logic                 has_data_o,
    output logic [63:0]          data_o,
    output logic                 err_parity_o,
    output logic                 err_opcode_o,
    output logic                 err_timeout_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    sb_state_e              state_q, state_d;
    sb_hdr_t                hdr_q, hdr_d, word_hdr;
    logic [63:0]            data_q, data_d;
    logic                   has_data_q, has_data_d;
    logic                   msg_valid_q, msg_valid_d;
    logic                   ack_q, ack_d;
    logic                   err_par_q, err_par_d;
    logic                   err_op_q, err_op_d;
    logic                   err_tmo_q, err_tmo_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   cap;
    logic                   cp_ok, dp_ok;

    assign word_hdr = sb_hdr_t'(word_i);

`ifdef SB_PARITY_CHECK_EN
    sb_hdr_t chk_hdr;

    // In DATA the stored header supplies DP while word_i carries the payload.
    assign chk_hdr = (state_q == SB_ST_DATA) ? hdr_q : word_hdr;

    sb_parity_chk u_parity_chk (
        .hdr_i      (chk_hdr),
        .data_i     (word_i),
        .has_data_i (state_q == SB_ST_DATA),
        .cp_ok_o    (cp_ok),
        .dp_ok_o    (dp_ok)
    );
`else
    logic unused_par_bits;

    assign cp_ok           = 1'b1;
    assign dp_ok           = 1'b1;
    assign unused_par_bits = ^{hdr_q.dp, hdr_q.cp, hdr_q.rsvd};
`endif

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        data_d      = data_q;
        has_data_d  = has_data_q;
        msg_valid_d = msg_valid_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_cnt_d   = err_cnt_q;
        ack_d       = 1'b0;
        err_par_d   = 1'b0;
        err_op_d    = 1'b0;
        err_tmo_d   = 1'b0;
        cap         = word_valid_i && !ack_q &&
                      (((state_q == SB_ST_IDLE) && enable_i) || (state_q == SB_ST_DATA));

        case (state_q)
            SB_ST_IDLE: begin
                if (cap) begin
                    ack_d = 1'b1;
                    if (word_hdr.opcode == SB_OPC_MSG_NODATA) begin
                        if (cp_ok && dp_ok) begin
                            hdr_d       = word_hdr;
                            data_d      = '0;
                            has_data_d  = 1'b0;
                            msg_valid_d = 1'b1;
                            state_d     = SB_ST_OUT;
                        end else begin
                            err_par_d = 1'b1;
                        end
                    end else if (word_hdr.opcode == SB_OPC_MSG_DATA) begin
                        if (cp_ok) begin
                            hdr_d     = word_hdr;
                            tmo_cnt_d = '0;
                            state_d   = SB_ST_DATA;
                        end else begin
                            err_par_d = 1'b1;
                        end
                    end else begin
                        err_op_d = 1'b1;
                    end
                end
            end
            SB_ST_DATA: begin
                // A word landing on the final timeout cycle still wins.
                if (cap) begin
                    ack_d = 1'b1;
                    if (dp_ok) begin
                        data_d      = word_i;
                        has_data_d  = 1'b1;
                        msg_valid_d = 1'b1;
                        state_d     = SB_ST_OUT;
                    end else begin
                        err_par_d = 1'b1;
                        state_d   = SB_ST_IDLE;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    state_d   = SB_ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            SB_ST_OUT: begin
                if (msg_ready_i) begin
                    msg_valid_d = 1'b0;
                    state_d     = SB_ST_IDLE;
                end
            end
            default: state_d = SB_ST_IDLE;
        endcase

        if ((err_par_d || err_op_d || err_tmo_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state_q     <= SB_ST_IDLE;
            hdr_q       <= '0;
            data_q      <= '0;
            has_data_q  <= 1'b0;
            msg_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            err_par_q   <= 1'b0;
            err_op_q    <= 1'b0;
            err_tmo_q   <= 1'b0;
            tmo_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            data_q      <= data_d;
            has_data_q  <= has_data_d;
            msg_valid_q <= msg_valid_d;
            ack_q       <= ack_d;
            err_par_q   <= err_par_d;
            err_op_q    <= err_op_d;
            err_tmo_q   <= err_tmo_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign word_ack_o    = ack_q;
    assign msg_valid_o   = msg_valid_q;
    assign opcode_o      = hdr_q.opcode;
    assign srcid_o       = hdr_q.srcid;
    assign dstid_o       = hdr_q.dstid;
    assign msgcode_o     = hdr_q.msgcode;
    assign msgsubcode_o  = hdr_q.msgsubcode;
    assign msginfo_o     = hdr_q.msginfo;
    assign has_data_o    = has_data_q;
    assign data_o        = data_q;
    assign err_parity_o  = err_par_q;
    assign err_opcode_o  = err_op_q;
    assign err_timeout_o = err_tmo_q;
    assign err_cnt_o     = err_cnt_q;

endmodule
